// File: rtl/alu_exec_ctrl_if.sv
// Bundle of instruction, ALU, writeback and debug signals around alu_exec_ctrl.
// The controller takes the slave side; the environment (fetch, ALU, debug host) takes the master side.
interface alu_exec_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_sa;
    logic [31:0] alu_r;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic        dbg_we;
    logic [4:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    modport master (
        output instr_valid, instr, alu_r, dbg_we, dbg_waddr, dbg_wdata, dbg_raddr,
        input  instr_ready, alu_op, alu_a, alu_b, alu_sa, wb_valid, wb_rd, wb_data,
               illegal, dbg_rdata
    );

    modport slave (
        input  instr_valid, instr, alu_r, dbg_we, dbg_waddr, dbg_wdata, dbg_raddr,
        output instr_ready, alu_op, alu_a, alu_b, alu_sa, wb_valid, wb_rd, wb_data,
               illegal, dbg_rdata
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Four-state R-type execute controller: read operands, run the external ALU, write back.
// Owns a 32x32 GPR file with a debug preload/read port.
module alu_exec_ctrl (
    input  logic           clk_i,
    input  logic           reset_i,
    alu_exec_ctrl_if.slave bus
);
    // state  | meaning
    // S_IDLE | ready for an instruction; debug writes honoured
    // S_READ | operands, funct and shamt registered toward the ALU
    // S_EXEC | ALU result captured
    // S_WB   | result written to GPR[rd]; writeback pulse follows
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRLV = 6'b000110;

    state_e      state_q, state_d;
    logic [25:0] instr_q, instr_d;
    logic [31:0] gpr_q [32];
    logic [5:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [5:0]  alu_sa_q, alu_sa_d;
    logic [31:0] res_q, res_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        illegal_q, illegal_d;

    logic        ready;
    logic        accept;
    logic        legal;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign rd    = instr_q[15:11];
    assign shamt = instr_q[10:6];
    assign funct = instr_q[5:0];

    assign ready  = (state_q == S_IDLE);
    assign accept = bus.instr_valid && ready;

    always_comb begin
        legal = 1'b0;
        if (bus.instr[31:26] == 6'd0) begin
            case (bus.instr[5:0])
                F_AND, F_OR, F_XOR, F_SLL, F_SLLV, F_SRL, F_SRLV: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sa_d   = alu_sa_q;
        res_d      = res_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        gpr_we     = 1'b0;
        gpr_waddr  = 5'd0;
        gpr_wdata  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    instr_d   = bus.instr[25:0];
                    illegal_d = !legal;
                    if (legal) state_d = S_READ;
                end
                if (bus.dbg_we) begin
                    gpr_we    = 1'b1;
                    gpr_waddr = bus.dbg_waddr;
                    gpr_wdata = bus.dbg_wdata;
                end
            end
            S_READ: begin
                alu_op_d = funct;
                alu_a_d  = gpr_q[rs];
                alu_b_d  = gpr_q[rt];
                alu_sa_d = {1'b0, shamt};
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                res_d   = bus.alu_r;
                state_d = S_WB;
            end
            S_WB: begin
                // Writeback outputs register alongside the GPR write so the pulse
                // appears exactly when the new value becomes readable.
                wb_valid_d = 1'b1;
                wb_rd_d    = rd;
                wb_data_d  = res_q;
                gpr_we     = 1'b1;
                gpr_waddr  = rd;
                gpr_wdata  = res_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sa_q   <= '0;
            res_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sa_q   <= alu_sa_d;
            res_q      <= res_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    // GPR[0] is cleared on reset and never written, so it always reads as zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else if (gpr_we && (gpr_waddr != 5'd0)) begin
            gpr_q[gpr_waddr] <= gpr_wdata;
        end
    end

    assign bus.instr_ready = ready;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_sa      = alu_sa_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.illegal     = illegal_q;
    assign bus.dbg_rdata   = gpr_q[bus.dbg_raddr];
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU on the alu_* bus.
module tb_alu_exec_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_op)
            6'b100100: bus.alu_r = bus.alu_a & bus.alu_b;
            6'b100101: bus.alu_r = bus.alu_a | bus.alu_b;
            6'b100110: bus.alu_r = bus.alu_a ^ bus.alu_b;
            6'b000000: bus.alu_r = bus.alu_b << bus.alu_sa;
            6'b000100: bus.alu_r = bus.alu_b << bus.alu_a[4:0];
            6'b000010: bus.alu_r = bus.alu_b >> bus.alu_sa;
            6'b000110: bus.alu_r = bus.alu_b >> bus.alu_a[4:0];
            default:   bus.alu_r = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        bus.dbg_raddr = a;
        #1;
        d = bus.dbg_rdata;
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        bus.dbg_we    = 1'b1;
        bus.dbg_waddr = a;
        bus.dbg_wdata = d;
        step(1);
        bus.dbg_we    = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        step(1);
        bus.instr_valid = 1'b0;
    endtask

    // Issue from IDLE and follow READ, EXEC, WB; ends in the IDLE cycle carrying the pulse.
    task automatic run(input string tag, input logic [31:0] w, input logic [4:0] rd,
                       input logic [31:0] data);
        logic [31:0] v;
        logic [31:0] exp_gpr;
        issue(w);
        check({tag, "/ready_read"}, bus.instr_ready, 32'd0);
        step(1);
        check({tag, "/alu_op"}, bus.alu_op, {26'd0, w[5:0]});
        check({tag, "/alu_sa"}, bus.alu_sa, {27'd0, w[10:6]});
        step(1);
        check({tag, "/wb_early"}, bus.wb_valid, 32'd0);
        step(1);
        check({tag, "/wb_valid"}, bus.wb_valid, 32'd1);
        check({tag, "/wb_rd"}, bus.wb_rd, {27'd0, rd});
        check({tag, "/wb_data"}, bus.wb_data, data);
        check({tag, "/ready_after"}, bus.instr_ready, 32'd1);
        exp_gpr = (rd == 5'd0) ? 32'd0 : data;
        peek(rd, v);
        check({tag, "/gpr_rd"}, v, exp_gpr);
    endtask

    initial begin
        logic [31:0] v;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.dbg_we      = 1'b0;
        bus.dbg_waddr   = 5'd0;
        bus.dbg_wdata   = 32'd0;
        bus.dbg_raddr   = 5'd0;
        step(3);
        check("rst/ready", bus.instr_ready, 32'd1);
        check("rst/wb_valid", bus.wb_valid, 32'd0);
        check("rst/illegal", bus.illegal, 32'd0);
        check("rst/alu_a", bus.alu_a, 32'd0);
        check("rst/alu_op", bus.alu_op, 32'd0);
        reset = 1'b0;
        step(1);
        check("post_rst/ready", bus.instr_ready, 32'd1);

        dbg_write(5'd1, 32'h0000FF0F);
        dbg_write(5'd2, 32'h00F0F0FF);
        dbg_write(5'd0, 32'hDEADBEEF);
        peek(5'd0, v);
        check("gpr0_ignores_write", v, 32'd0);
        peek(5'd1, v);
        check("gpr1_preload", v, 32'h0000FF0F);

        run("and", 32'h00221824, 5'd3, 32'h0000F00F);

        dbg_write(5'd2, 32'h00000001);
        run("sll", 32'h000227C0, 5'd4, 32'h80000000);
        run("srl", 32'h00042902, 5'd5, 32'h08000000);
        step(1);
        check("wb_one_cycle", bus.wb_valid, 32'd0);
        run("sllv", 32'h00224004, 5'd8, 32'h00008000);
        run("srlv", 32'h00284806, 5'd9, 32'h00000001);

        issue(32'h00221820);
        check("add/illegal", bus.illegal, 32'd1);
        check("add/ready", bus.instr_ready, 32'd1);
        check("add/wb_valid", bus.wb_valid, 32'd0);
        step(1);
        check("add/illegal_drop", bus.illegal, 32'd0);
        issue(32'h20221824);
        check("op8/illegal", bus.illegal, 32'd1);
        check("op8/ready", bus.instr_ready, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("illegal/no_wb", bus.wb_valid, 32'd0);
        end
        peek(5'd3, v);
        check("illegal/gpr3_kept", v, 32'h0000F00F);

        run("or_r0", 32'h00220025, 5'd0, 32'h0000FF0F);
        run("nop", 32'h00000000, 5'd0, 32'h00000000);

        // xor $6 interrupted by reset in EXEC; handshake and dbg_we held during reset.
        issue(32'h00223026);
        step(1);
        reset           = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h00221824;
        bus.dbg_we      = 1'b1;
        bus.dbg_waddr   = 5'd10;
        bus.dbg_wdata   = 32'h12345678;
        step(1);
        check("rst_exec/wb_valid", bus.wb_valid, 32'd0);
        check("rst_exec/alu_a", bus.alu_a, 32'd0);
        check("rst_exec/alu_b", bus.alu_b, 32'd0);
        check("rst_exec/alu_op", bus.alu_op, 32'd0);
        step(1);
        reset           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.dbg_we      = 1'b0;
        check("rst_hold/illegal", bus.illegal, 32'd0);
        check("rst_hold/wb_valid", bus.wb_valid, 32'd0);
        step(1);
        check("rst_exec/ready_after", bus.instr_ready, 32'd1);
        check("rst_exec/no_wb_after", bus.wb_valid, 32'd0);
        for (int i = 0; i < 32; i++) begin
            peek(i[4:0], v);
            check("rst_exec/gpr_clear", v, 32'd0);
        end

        // or $7,$1,$0 with a same-cycle preload; a preload during EXEC must be dropped.
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h00203825;
        bus.dbg_we      = 1'b1;
        bus.dbg_waddr   = 5'd1;
        bus.dbg_wdata   = 32'hAAAAAAAA;
        step(1);
        bus.instr_valid = 1'b0;
        bus.dbg_we      = 1'b0;
        step(1);
        bus.dbg_we      = 1'b1;
        bus.dbg_waddr   = 5'd1;
        bus.dbg_wdata   = 32'h12345678;
        step(1);
        bus.dbg_we      = 1'b0;
        check("or7/wb_early", bus.wb_valid, 32'd0);
        step(1);
        check("or7/wb_valid", bus.wb_valid, 32'd1);
        check("or7/wb_rd", bus.wb_rd, 32'd7);
        check("or7/wb_data", bus.wb_data, 32'hAAAAAAAA);
        peek(5'd1, v);
        check("or7/exec_dbg_ignored", v, 32'hAAAAAAAA);
        peek(5'd7, v);
        check("or7/gpr7", v, 32'hAAAAAAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 instr_valid  input  1  instruction word offered.
REQ-005 instr_ready  output  1  block can accept an instruction.
REQ-006 instr  input  32  MIPS R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-007 alu_op  output  6  function code to the downstream ALU.
REQ-008 alu_a  output  32  operand A, equal to GPR[rs].
REQ-009 alu_b  output  32  operand B, equal to GPR[rt].
REQ-010 alu_sa  output  6  shift amount, equal to {1'b0, shamt}.
REQ-011 alu_r  input  32  combinational ALU result.
REQ-012 wb_valid  output  1  one-cycle pulse marking writeback.
REQ-013 wb_rd  output  5  writeback destination.
REQ-014 wb_data  output  32  writeback value.
REQ-015 illegal  output  1  one-cycle pulse for a rejected instruction.
REQ-016 dbg_we, dbg_waddr[4:0], dbg_wdata[31:0]  input  preload write port.
REQ-017 dbg_raddr  input  5  debug read address.
REQ-018 dbg_rdata  output  32  combinational GPR[dbg_raddr].

Function
REQ-019 The register file SHALL be 32 x 32 bits; GPR[0] SHALL read as 0 and ignore all writes.
REQ-020 The FSM SHALL have four states, IDLE -> READ -> EXEC -> WB -> IDLE, with exactly one transition per clk edge outside IDLE.
REQ-021 instr_ready SHALL be 1 only in IDLE; an instruction is accepted when instr_valid & instr_ready.
REQ-022 On accept, the block SHALL latch instr. If op != 0 or funct is not in {100100 and, 100101 or, 100110 xor, 000000 sll, 000100 sllv, 000010 srl, 000110 srlv}, it SHALL pulse illegal for the next cycle, remain in IDLE, and make no register write.
REQ-023 On accept of a legal instruction, the FSM SHALL go to READ.
REQ-024 READ: the block SHALL register GPR[rs] into the A operand, GPR[rt] into the B operand, funct into alu_op, and {1'b0, shamt} into alu_sa.
REQ-025 alu_op, alu_a, alu_b and alu_sa SHALL be driven from those registers in every state; the ALU result is defined only in EXEC.
REQ-026 EXEC: the block SHALL capture alu_r into a result register at the end of the cycle.
REQ-027 WB: wb_valid SHALL be 1, with wb_rd = rd and wb_data = the result register; GPR[rd] SHALL be written at the end of WB unless rd == 0.
REQ-028 rd == 0 (including the NOP word 0x00000000) SHALL still produce a wb_valid pulse, with no register write.
REQ-029 Latency: for a handshake at edge T, wb_valid SHALL be high in the cycle after edge T+3. Throughput SHALL be one instruction per 4 cycles.
REQ-030 dbg_we SHALL be honoured only in IDLE and ignored in every other state.
REQ-031 dbg_we in the same cycle as an accept SHALL be performed; the accepted instruction's READ SHALL see the new value.
REQ-032 A WB write to register X followed by an instruction reading X SHALL return the written value; no bypass is needed.
REQ-033 All outputs SHALL be registered except instr_ready and dbg_rdata.

Reset
REQ-034 While reset is high, the FSM SHALL go to IDLE, all GPRs SHALL clear to 0, and all registered outputs SHALL be 0: alu_op, alu_a, alu_b, alu_sa, wb_valid, wb_rd, wb_data, illegal.
REQ-035 Reset in READ, EXEC or WB SHALL drop the in-flight instruction, with no GPR write and no wb_valid.
REQ-036 instr_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-037 Reset SHALL take priority over dbg_we and over the handshake in the same cycle.

Verification
REQ-038 Scenario: dbg write GPR1=0x0000FF0F, GPR2=0x00F0F0FF, then issue and $3,$1,$2 (0x00221824) -> wb_valid 3 cycles after accept, wb_rd=3, wb_data=0x0000F00F, dbg_rdata(3)=0x0000F00F.
REQ-039 Scenario: GPR2=0x00000001, issue sll $4,$2,31 (0x000227C0) -> alu_sa=0x1F during EXEC, wb_data=0x80000000; then srl $5,$4,4 (0x00042902) -> wb_data=0x08000000.
REQ-040 Scenario: issue add (funct 100000) or op=0x08 -> illegal pulse 1 cycle, instr_ready stays 1, all GPRs unchanged, no wb_valid.
REQ-041 Scenario: issue or $0,$1,$2 and the NOP 0x00000000 -> wb_valid pulses with wb_rd=0, dbg_rdata(0)=0.
REQ-042 Scenario: assert reset during EXEC of xor $6,$1,$2 -> no wb_valid, GPR6=0, all GPRs 0, instr_ready=1 the cycle after reset drops.
REQ-043 Scenario: back-to-back valid with dbg_we GPR1=0xAAAAAAAA at accept of or $7,$1,$0 -> wb_data=0xAAAAAAAA; a dbg_we during EXEC is ignored.
